mac_pipe_sat: RTL and testbench
===============================

Name: mac_pipe_sat

Overview:
Parametrised, pipelined signed multiply-accumulate unit. It is the next generation of the team's fixed 8x8/16-bit MAC.
- Adds configurable operand and accumulator widths and a configurable multiplier pipeline depth.
- Adds a valid-qualified input stream, so bubbles do not accumulate.
- Adds a per-sample clear that starts a new accumulation.
- Adds optional saturation and a sticky overflow flag.
- Sits in the datapath feeding filter/dot-product accumulators.

Parameters:
- IN_W, 8: signed operand width of a and b.
- ACC_W, 16: signed accumulator/output width. Must satisfy ACC_W >= 2*IN_W; elaboration error otherwise.
- MULT_STAGES, 1: number of product pipeline registers between the input register and the accumulator. Legal range 1..4.
- SATURATE, 1: 1 = clamp accumulator to signed ACC_W range; 0 = two's-complement wrap.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- valid_in, input, 1: a, b and clear_in are valid this cycle.
- clear_in, input, 1: this sample starts a new accumulation (acc := product). Qualified by valid_in.
- a, input, IN_W: signed multiplicand.
- b, input, IN_W: signed multiplier.
- f, output, ACC_W: signed accumulator value (registered).
- valid_out, output, 1: one-cycle pulse; f was updated by a sample on this edge.
- overflow, output, 1: sticky; set when any accumulation exceeded the signed ACC_W range.

Behaviour:
- Reset: clk is the clock; reset is synchronous and active-high.
  - Reset clears all pipeline data and valid bits.
  - Reset values: f=0, valid_out=0, overflow=0.
  - Samples in flight when reset is asserted are discarded. No valid_out is produced for them after reset deasserts.
- Stage 0 (input register): captures a, b, clear_in and valid_in every edge when not in reset.
- Product pipeline:
  - Full-precision signed product, 2*IN_W bits, computed from the stage-0 registers.
  - The product passes through MULT_STAGES registers, each carrying the product, valid and clear tag.
  - Stages load every cycle; there is no stall or back-pressure.
- Accumulator stage: acts on the last pipeline stage when its valid bit is 1.
  - Product is sign-extended to ACC_W+1 bits.
  - If clear tag = 1: sum = product.
  - If clear tag = 0: sum = sign-extended f + product.
  - Range check: sum is out of range if sum > 2^(ACC_W-1)-1 or sum < -2^(ACC_W-1).
  - SATURATE=1: f := clamp(sum), i.e. max positive or min negative.
  - SATURATE=0: f := sum[ACC_W-1:0].
  - valid_out=1 for that cycle.
- Bubbles: when the last-stage valid bit is 0, f holds and valid_out=0.
- Latency: a sample presented with valid_in=1 before edge k updates f and raises valid_out on edge k+MULT_STAGES+1.
  - That is MULT_STAGES+2 edges counting the sampling edge.
  - Default latency is 3 edges.
  - Throughput is one sample per cycle.
- Overflow flag:
  - Set to 1 on any out-of-range sum. Since ACC_W >= 2*IN_W, this only occurs for non-clear samples.
  - A clear-tagged sample that is itself in range sets overflow := 0; the flag is cleared at the same edge f is reloaded.
  - Otherwise overflow holds.
- Simultaneous events: reset has priority over any valid sample at the accumulator.
- clear_in with valid_in=0 is ignored.
- Edge operands: -2^(IN_W-1) * -2^(IN_W-1) = 2^(2*IN_W-2) fits the product width without special handling.
- Before the first clear, accumulation starts from f=0 (post-reset value).

Test Plan (IN_W=8, ACC_W=16, MULT_STAGES=1, SATURATE=1 unless noted):
1. Basic: reset, then back-to-back valid samples (1,2,clear), (-3,4), (2,8) -> valid_out pulses on edges 3, 4, 5 after the first sample; f = 2, -10, 6; overflow=0.
2. Bubbles and clear: samples (5,5,clear), gap of 3 idle cycles, (2,3), then (1,1,clear) -> f = 25, holds 25 through the gap with valid_out=0, then 31, then 1.
3. Positive saturation: (127,127,clear) x1, then (127,127) x2, then (-128,127) -> f = 16129, 32258, 32767 with overflow=1, then 16511 with overflow still 1. A following (0,0,clear) gives f=0 and overflow=0.
4. Wrap mode (SATURATE=0): same first three samples as scenario 3 -> f = 16129, 32258, -17149; overflow=1.
5. Negative saturation and extreme operands:
   - (-128,127,clear), (-128,127), (-128,127) -> f = -16256, -32512, -32768; overflow=1.
   - Then (-128,-128,clear) -> f=16384, overflow=0.
6. Reset mid-flight and depth: with MULT_STAGES=3, issue 2 valid samples, assert reset for 1 cycle -> f=0, overflow=0, and no valid_out ever appears for the discarded samples. A fresh (3,3,clear) then yields f=9 exactly 5 edges after sampling.

Source files
------------

// File: rtl/mac_pipe_sat.sv
`default_nettype none
// ============================================================================
// Module   : mac_pipe_sat
// Brief    : Parametrised pipelined signed multiply-accumulate with a
//            valid-qualified input stream, per-sample clear, optional
//            saturation and a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module mac_pipe_sat #(
    parameter int IN_W        = 8,
    parameter int ACC_W       = 16,
    parameter int MULT_STAGES = 1,
    parameter int SATURATE    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    input  logic                    clear_in,
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    output logic signed [ACC_W-1:0] f,
    output logic                    valid_out,
    output logic                    overflow
);

    localparam int c_PROD_W = 2 * IN_W;
    localparam int c_SUM_W  = ACC_W + 1;
    localparam int c_EXT_W  = c_SUM_W - c_PROD_W;

    // Largest positive and most negative values representable in ACC_W bits.
    localparam logic signed [ACC_W-1:0] c_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    generate
        if (ACC_W < 2 * IN_W) begin : g_chk_acc_w
            $error("mac_pipe_sat: ACC_W must be >= 2*IN_W");
        end
        if (MULT_STAGES < 1 || MULT_STAGES > 4) begin : g_chk_stages
            $error("mac_pipe_sat: MULT_STAGES must be in 1..4");
        end
        if (SATURATE != 0 && SATURATE != 1) begin : g_chk_sat
            $error("mac_pipe_sat: SATURATE must be 0 or 1");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Stage 0: input register
    // ------------------------------------------------------------------------
    logic signed [IN_W-1:0] r_a;
    logic signed [IN_W-1:0] r_b;
    logic                   r_vld0;
    logic                   r_clr0;

    // Capture operands and tags every cycle; a clear without valid is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_vld0 <= 1'b0;
            r_clr0 <= 1'b0;
        end else begin
            r_a    <= a;
            r_b    <= b;
            r_vld0 <= valid_in;
            r_clr0 <= clear_in & valid_in;
        end
    end

    // Full-precision product; -2^(IN_W-1) squared still fits in 2*IN_W bits.
    logic signed [c_PROD_W-1:0] w_prod;
    assign w_prod = r_a * r_b;

    // ------------------------------------------------------------------------
    // Product pipeline: MULT_STAGES registers carrying product, valid, clear
    // ------------------------------------------------------------------------
    logic signed [c_PROD_W-1:0] r_prod [MULT_STAGES];
    logic                       r_vld  [MULT_STAGES];
    logic                       r_clr  [MULT_STAGES];

    // Shift product and tags down the pipe every cycle; no stall exists.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MULT_STAGES; i++) begin
                r_prod[i] <= '0;
                r_vld[i]  <= 1'b0;
                r_clr[i]  <= 1'b0;
            end
        end else begin
            r_prod[0] <= w_prod;
            r_vld[0]  <= r_vld0;
            r_clr[0]  <= r_clr0;
            for (int i = 1; i < MULT_STAGES; i++) begin
                r_prod[i] <= r_prod[i-1];
                r_vld[i]  <= r_vld[i-1];
                r_clr[i]  <= r_clr[i-1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Accumulator datapath
    // ------------------------------------------------------------------------
    logic signed [c_PROD_W-1:0] w_last_prod;
    logic                       w_last_vld;
    logic                       w_last_clr;
    logic signed [c_SUM_W-1:0]  w_prod_ext;
    logic signed [c_SUM_W-1:0]  w_f_ext;
    logic signed [c_SUM_W-1:0]  w_sum;
    logic                       w_oor;
    logic signed [ACC_W-1:0]    w_next_f;

    assign w_last_prod = r_prod[MULT_STAGES-1];
    assign w_last_vld  = r_vld[MULT_STAGES-1];
    assign w_last_clr  = r_clr[MULT_STAGES-1];

    assign w_prod_ext = {{c_EXT_W{w_last_prod[c_PROD_W-1]}}, w_last_prod};
    assign w_f_ext    = {f[ACC_W-1], f};

    // One guard bit is enough: both addends lie within the ACC_W range.
    assign w_sum = w_last_clr ? w_prod_ext : (w_f_ext + w_prod_ext);

    // Outside the ACC_W range exactly when the guard bit disagrees with the
    // ACC_W sign bit.
    assign w_oor = w_sum[ACC_W] ^ w_sum[ACC_W-1];

    generate
        if (SATURATE != 0) begin : g_sat
            // Clamp toward the sign of the true sum held in the guard bit.
            always_comb begin
                w_next_f = w_sum[ACC_W-1:0];
                if (w_oor) begin
                    w_next_f = w_sum[ACC_W] ? c_ACC_MIN : c_ACC_MAX;
                end
            end
        end else begin : g_wrap
            assign w_next_f = w_sum[ACC_W-1:0];
        end
    endgenerate

    // Update f and flags on a valid last-stage sample; bubbles hold state.
    always_ff @(posedge clk) begin
        if (reset) begin
            f         <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            valid_out <= w_last_vld;
            if (w_last_vld) begin
                f <= w_next_f;
                if (w_oor) begin
                    overflow <= 1'b1;
                end else if (w_last_clr) begin
                    overflow <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_pipe_sat.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_pipe_sat
// Brief    : Scoreboard bench for mac_pipe_sat. One shared stimulus stream
//            drives three instances (default, wrap mode, three-stage pipe);
//            each instance has its own expected queue and monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_pipe_sat;

    typedef struct {
        int f;
        bit o;
        int cyc;
    } exp_t;

    logic                clk;
    logic                reset;
    logic                valid_in;
    logic                clear_in;
    logic signed [7:0]   a;
    logic signed [7:0]   b;
    logic signed [15:0]  f0, f1, f2;
    logic                v0, v1, v2;
    logic                o0, o1, o2;

    int   cyc;
    bit   rst_q = 1'b1;
    int   checks;
    int   failures;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   last_f [3];
    bit   last_o [3];

    mac_pipe_sat #(.IN_W(8), .ACC_W(16), .MULT_STAGES(1), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .valid_in(valid_in), .clear_in(clear_in),
        .a(a), .b(b), .f(f0), .valid_out(v0), .overflow(o0));

    mac_pipe_sat #(.IN_W(8), .ACC_W(16), .MULT_STAGES(1), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .valid_in(valid_in), .clear_in(clear_in),
        .a(a), .b(b), .f(f1), .valid_out(v1), .overflow(o1));

    mac_pipe_sat #(.IN_W(8), .ACC_W(16), .MULT_STAGES(3), .SATURATE(1)) u_deep (
        .clk(clk), .reset(reset), .valid_in(valid_in), .clear_in(clear_in),
        .a(a), .b(b), .f(f2), .valid_out(v2), .overflow(o2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter and registered view of reset as seen by the DUT edge.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    // Per-instance comparison against its expected queue or held state.
    task automatic chk(input int d, input logic v, input logic signed [15:0] fv, input logic ov);
        exp_t e;
        int   sz;
        logic signed [15:0] ef;
        case (d)
            0: sz = q0.size();
            1: sz = q1.size();
            default: sz = q2.size();
        endcase
        checks++;
        if (rst_q) begin
            if (v !== 1'b0 || fv !== 16'sd0 || ov !== 1'b0) begin
                failures++;
                $display("FAIL reset dut%0d cyc=%0d f=%0d v=%b ovf=%b required f=0 v=0 ovf=0", d, cyc, fv, v, ov);
            end
            last_f[d] = 0;
            last_o[d] = 1'b0;
        end else if (v === 1'b1) begin
            if (sz == 0) begin
                failures++;
                $display("FAIL unexpected_valid dut%0d cyc=%0d f=%0d required no valid_out", d, cyc, fv);
            end else begin
                case (d)
                    0: e = q0.pop_front();
                    1: e = q1.pop_front();
                    default: e = q2.pop_front();
                endcase
                ef = 16'(e.f);
                if (fv !== ef || ov !== e.o || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL result dut%0d cyc=%0d f=%0d ovf=%b required cyc=%0d f=%0d ovf=%b",
                             d, cyc, fv, ov, e.cyc, ef, e.o);
                end
                last_f[d] = e.f;
                last_o[d] = e.o;
            end
        end else begin
            ef = 16'(last_f[d]);
            if (v !== 1'b0 || fv !== ef || ov !== last_o[d]) begin
                failures++;
                $display("FAIL hold dut%0d cyc=%0d f=%0d v=%b ovf=%b required f=%0d v=0 ovf=%b",
                         d, cyc, fv, v, ov, ef, last_o[d]);
            end
            if (sz > 0) begin
                case (d)
                    0: e = q0[0];
                    1: e = q1[0];
                    default: e = q2[0];
                endcase
                if (e.cyc <= cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL missing_valid dut%0d cyc=%0d required valid_out at cyc=%0d f=%0d", d, cyc, e.cyc, e.f);
                    case (d)
                        0: void'(q0.pop_front());
                        1: void'(q1.pop_front());
                        default: void'(q2.pop_front());
                    endcase
                end
            end
        end
    endtask

    // Monitor: samples all instances on the falling edge.
    always @(negedge clk) begin
        chk(0, v0, f0, o0);
        chk(1, v1, f1, o1);
        chk(2, v2, f2, o2);
    end

    // Issue one valid sample; es/os are saturating results, ew/ow wrap results.
    task automatic send(input logic signed [7:0] ta, input logic signed [7:0] tb,
                        input logic tclr, input int es, input bit os,
                        input int ew, input bit ow, input bit push);
        valid_in = 1'b1;
        clear_in = tclr;
        a        = ta;
        b        = tb;
        if (push) begin
            q0.push_back('{es, os, cyc + 3});
            q1.push_back('{ew, ow, cyc + 3});
            q2.push_back('{es, os, cyc + 5});
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        clear_in = 1'b0;
    endtask

    task automatic idle(input int n, input logic tclr);
        valid_in = 1'b0;
        clear_in = tclr;
        a        = 8'sd77;
        b        = -8'sd9;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        clear_in = 1'b0;
    endtask

    initial begin
        cyc      = 0;
        checks   = 0;
        failures = 0;
        last_f   = '{0, 0, 0};
        last_o   = '{1'b0, 1'b0, 1'b0};
        reset    = 1'b1;
        valid_in = 1'b0;
        clear_in = 1'b0;
        a        = '0;
        b        = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic back-to-back accumulation
        send(8'sd1,  8'sd2, 1'b1,   2, 1'b0,   2, 1'b0, 1'b1);
        send(-8'sd3, 8'sd4, 1'b0, -10, 1'b0, -10, 1'b0, 1'b1);
        send(8'sd2,  8'sd8, 1'b0,   6, 1'b0,   6, 1'b0, 1'b1);

        // Bubbles (with an unqualified clear in the gap) and clear
        send(8'sd5, 8'sd5, 1'b1, 25, 1'b0, 25, 1'b0, 1'b1);
        idle(3, 1'b1);
        send(8'sd2, 8'sd3, 1'b0, 31, 1'b0, 31, 1'b0, 1'b1);
        send(8'sd1, 8'sd1, 1'b1,  1, 1'b0,  1, 1'b0, 1'b1);

        // Positive saturation versus wrap
        send(8'sd127,  8'sd127, 1'b1, 16129, 1'b0,  16129, 1'b0, 1'b1);
        send(8'sd127,  8'sd127, 1'b0, 32258, 1'b0,  32258, 1'b0, 1'b1);
        send(8'sd127,  8'sd127, 1'b0, 32767, 1'b1, -17149, 1'b1, 1'b1);
        send(-8'sd128, 8'sd127, 1'b0, 16511, 1'b1,  32131, 1'b1, 1'b1);
        send(8'sd0,    8'sd0,   1'b1,     0, 1'b0,      0, 1'b0, 1'b1);

        // Negative saturation and extreme operands
        send(-8'sd128, 8'sd127,  1'b1, -16256, 1'b0, -16256, 1'b0, 1'b1);
        send(-8'sd128, 8'sd127,  1'b0, -32512, 1'b0, -32512, 1'b0, 1'b1);
        send(-8'sd128, 8'sd127,  1'b0, -32768, 1'b1,  16768, 1'b1, 1'b1);
        send(-8'sd128, -8'sd128, 1'b1,  16384, 1'b0,  16384, 1'b0, 1'b1);
        send(8'sd127,  8'sd127,  1'b0,  32513, 1'b0,  32513, 1'b0, 1'b1);
        send(8'sd127,  8'sd127,  1'b0,  32767, 1'b1, -16894, 1'b1, 1'b1);
        idle(7, 1'b0);

        // Reset with two samples in flight: they must never appear
        send(8'sd50, 8'sd50, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
        send(8'sd60, 8'sd60, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(8, 1'b0);

        // Accumulation after reset starts from zero, then a fresh clear
        send(8'sd2, -8'sd5, 1'b0, -10, 1'b0, -10, 1'b0, 1'b1);
        send(8'sd3,  8'sd3, 1'b1,   9, 1'b0,   9, 1'b0, 1'b1);

        // Bounded drain of outstanding expectations
        for (int i = 0; i < 20 && (q0.size() + q1.size() + q2.size()) > 0; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if ((q0.size() + q1.size() + q2.size()) != 0) begin
            failures++;
            $display("FAIL drain outstanding=%0d required 0", q0.size() + q1.size() + q2.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
